// File: rtl/rv32i_prefetch_unit.sv
// RV32I instruction prefetcher: issues sequential AXI4 reads under a credit limit,
// buffers responses in a show-ahead FIFO and discards responses made stale by redirects.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_0000
`endif

module rv32i_prefetch_unit #(
    parameter int                      FIFO_DEPTH      = 4,
    parameter int                      MAX_OUTSTANDING = 2,
    parameter logic [`DATA_WIDTH-1:0]  RESET_PC        = `BOOT_ADDR
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [`AXI_ADDR_WIDTH-1:0]  M_AXI_ARADDR,
    output logic [`AXI_PROT_WIDTH-1:0]  M_AXI_ARPROT,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [`AXI_DATA_WIDTH-1:0]  M_AXI_RDATA,
    input  logic [`AXI_RESP_WIDTH-1:0]  M_AXI_RRESP,
    input  logic                        fetch_stall,
    input  logic                        redirect_valid,
    input  logic [`DATA_WIDTH-1:0]      redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [`INSTR_WIDTH-1:0]     instr,
    output logic [`DATA_WIDTH-1:0]      instr_pc,
    output logic                        instr_fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_OUT_C = MAX_OUTSTANDING[CW-1:0];
    localparam logic [CW-1:0] FULL_C    = FIFO_DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_C   = FIFO_DEPTH[CW:0];
    localparam logic [PW-1:0] PTR_ONE_C = {{(PW-1){1'b0}}, 1'b1};

    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic                  arvalid_r;
    logic [31:0]           araddr_r;
    logic                  ar_stale_r;
    logic [31:0]           fetch_pc_r;
    logic [31:0]           resp_pc_r;
    logic [CW-1:0]         outstanding_r;
    logic [CW-1:0]         stale_cnt_r;
    logic [CW-1:0]         count_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [31:0]           mem_data_r  [FIFO_DEPTH];
    logic [31:0]           mem_pc_r    [FIFO_DEPTH];
    logic                  mem_fault_r [FIFO_DEPTH];

    logic                  ar_fire_s;
    logic                  ar_hold_s;
    logic                  r_take_s;
    logic                  r_stale_s;
    logic                  push_s;
    logic                  push_ok_s;
    logic                  pop_s;
    logic                  stale_inc_s;
    logic                  stale_dec_s;
    logic                  issue_s;
    logic [31:0]           redir_pc_s;
    logic [CW-1:0]         out_next_s;
    logic [CW-1:0]         count_next_s;
    logic [CW-1:0]         stale_next_s;
    logic [31:0]           fetch_pc_next_s;
    logic                  arvalid_next_s;
    logic [31:0]           araddr_next_s;
    logic                  ar_stale_next_s;

    assign ar_fire_s   = arvalid_r & M_AXI_ARREADY;
    assign ar_hold_s   = arvalid_r & ~M_AXI_ARREADY;
    assign r_take_s    = M_AXI_RVALID & (outstanding_r != ZERO_C);
    // Stale responses always precede fresh ones because AXI returns reads in order.
    assign r_stale_s   = redirect_valid | (stale_cnt_r != ZERO_C);
    assign push_s      = r_take_s & ~r_stale_s;
    assign pop_s       = (count_r != ZERO_C) & instr_ready & ~redirect_valid;
    assign push_ok_s   = push_s & ((count_r != FULL_C) | pop_s);
    assign stale_inc_s = ar_fire_s & ar_stale_r;
    assign stale_dec_s = r_take_s & (stale_cnt_r != ZERO_C);
    assign redir_pc_s  = redirect_pc & 32'hFFFF_FFFC;

    // Next-state for credit counters, fetch address and the AR channel.
    always_comb begin
        out_next_s      = outstanding_r;
        count_next_s    = count_r;
        stale_next_s    = stale_cnt_r;
        fetch_pc_next_s = fetch_pc_r;
        arvalid_next_s  = 1'b0;
        araddr_next_s   = araddr_r;
        ar_stale_next_s = ar_stale_r;
        issue_s         = 1'b0;

        if (ar_fire_s && !r_take_s) begin
            out_next_s = outstanding_r + ONE_C;
        end else if (!ar_fire_s && r_take_s) begin
            out_next_s = outstanding_r - ONE_C;
        end else begin
            out_next_s = outstanding_r;
        end

        if (redirect_valid) begin
            count_next_s = ZERO_C;
        end else if (push_ok_s && !pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end

        if (redirect_valid) begin
            stale_next_s = out_next_s;
        end else if (stale_inc_s && !stale_dec_s) begin
            stale_next_s = stale_cnt_r + ONE_C;
        end else if (!stale_inc_s && stale_dec_s) begin
            stale_next_s = stale_cnt_r - ONE_C;
        end else begin
            stale_next_s = stale_cnt_r;
        end

        if (redirect_valid) begin
            fetch_pc_next_s = redir_pc_s;
        end else if (ar_fire_s && !ar_stale_r) begin
            fetch_pc_next_s = pc_step(fetch_pc_r);
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end

        // A held AR at redirect time is still owed to the slave; mark it stale.
        if (ar_hold_s && redirect_valid) begin
            ar_stale_next_s = 1'b1;
        end else if (ar_fire_s) begin
            ar_stale_next_s = 1'b0;
        end else begin
            ar_stale_next_s = ar_stale_r;
        end

        issue_s = !fetch_stall && !redirect_valid && (out_next_s < MAX_OUT_C) &&
                  (({1'b0, count_next_s} + {1'b0, out_next_s}) < DEPTH_C);

        if (ar_hold_s) begin
            arvalid_next_s = 1'b1;
            araddr_next_s  = araddr_r;
        end else if (issue_s) begin
            arvalid_next_s = 1'b1;
            araddr_next_s  = fetch_pc_next_s;
        end else begin
            arvalid_next_s = 1'b0;
            araddr_next_s  = araddr_r;
        end
    end

    // Control and credit state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            arvalid_r     <= 1'b0;
            araddr_r      <= RESET_PC;
            ar_stale_r    <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= ZERO_C;
            stale_cnt_r   <= ZERO_C;
            count_r       <= ZERO_C;
        end else begin
            arvalid_r     <= arvalid_next_s;
            araddr_r      <= araddr_next_s;
            ar_stale_r    <= ar_stale_next_s;
            fetch_pc_r    <= fetch_pc_next_s;
            outstanding_r <= out_next_s;
            stale_cnt_r   <= stale_next_s;
            count_r       <= count_next_s;
            if (redirect_valid) begin
                resp_pc_r <= redir_pc_s;
            end else if (push_s) begin
                resp_pc_r <= pc_step(resp_pc_r);
            end else begin
                resp_pc_r <= resp_pc_r;
            end
        end
    end

    // Instruction buffer storage and pointers; a redirect flushes it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i]  <= 32'h0000_0000;
                mem_pc_r[i]    <= 32'h0000_0000;
                mem_fault_r[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_data_r[wr_ptr_r]  <= M_AXI_RDATA;
                mem_pc_r[wr_ptr_r]    <= resp_pc_r;
                mem_fault_r[wr_ptr_r] <= (M_AXI_RRESP != 2'b00);
                wr_ptr_r              <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARPROT  = 3'b100;
    assign M_AXI_RREADY  = 1'b1;
    assign instr_valid   = (count_r != ZERO_C);
    assign instr         = mem_data_r[rd_ptr_r];
    assign instr_pc      = mem_pc_r[rd_ptr_r];
    assign instr_fault   = mem_fault_r[rd_ptr_r];

endmodule

// File: tb/tb_rv32i_prefetch_unit.sv
// Directed bench for rv32i_prefetch_unit with a small in-order AXI read slave model.
`timescale 1ns/1ps
module tb_rv32i_prefetch_unit;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA = 32'h0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        fetch_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rready_low = 0;
    bit ar_ready_en = 1'b1;
    bit fault_en = 1'b0;
    int r_delay = 0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] ar_log[$];
    logic [31:0] out_pc[$];
    logic [31:0] out_data[$];
    logic        out_fault[$];
    int          out_cyc[$];

    rv32i_prefetch_unit #(
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP),
        .fetch_stall(fetch_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_fault(instr_fault)
    );

    always #5 CLK = ~CLK;

    // Handshake sampling on the active edge: slave queue, AR log, consumed-instruction log.
    always @(posedge CLK) begin
        if (!RSTn) begin
            pend_addr.delete();
            pend_due.delete();
            ar_log.delete();
            out_pc.delete();
            out_data.delete();
            out_fault.delete();
            out_cyc.delete();
        end else begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                pend_addr.push_back(M_AXI_ARADDR);
                pend_due.push_back(cyc + 1 + r_delay);
                ar_log.push_back(M_AXI_ARADDR);
            end
            if (M_AXI_RVALID && M_AXI_RREADY && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                out_pc.push_back(instr_pc);
                out_data.push_back(instr);
                out_fault.push_back(instr_fault);
                out_cyc.push_back(cyc);
            end
        end
        cyc = cyc + 1;
    end

    // Slave drive on the inactive edge; instruction word is the inverted address.
    always @(negedge CLK) begin
        if (RSTn && !M_AXI_RREADY) rready_low++;
        M_AXI_ARREADY = ar_ready_en;
        if (RSTn && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = ~pend_addr[0];
            M_AXI_RRESP  = (fault_en && pend_addr[0] == 32'h4) ? 2'b10 : 2'b00;
        end else begin
            M_AXI_RVALID = 1'b0;
            M_AXI_RDATA  = 32'h0;
            M_AXI_RRESP  = 2'b00;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < out_pc.size()) ? out_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < out_data.size()) ? out_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] fault_at(input int i);
        return (i < out_fault.size()) ? {31'b0, out_fault[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ar_at(input int i);
        return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input bit ar_rdy, input int delay, input bit rdy, input bit flt);
        RSTn           = 1'b0;
        fetch_stall    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ar_ready_en    = ar_rdy;
        r_delay        = delay;
        instr_ready    = rdy;
        fault_en       = flt;
        repeat (3) tick();
        check_value("rst_arvalid", {31'b0, M_AXI_ARVALID}, 32'd0);
        check_value("rst_ivalid", {31'b0, instr_valid}, 32'd0);
        check_value("rst_instr", instr, 32'd0);
        check_value("rst_ipc", instr_pc, 32'd0);
        check_value("rst_ifault", {31'b0, instr_fault}, 32'd0);
        check_value("arprot", {29'b0, M_AXI_ARPROT}, 32'd4);
        RSTn = 1'b1;
    endtask

    task automatic wait_ar(input int n);
        int k;
        k = 0;
        while (ar_log.size() < n && k < 200) begin
            tick();
            k++;
        end
        check_value("wait_ar", (ar_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] e;

        // Zero-wait streaming from reset
        do_reset(1'b1, 0, 1'b1, 1'b0);
        tick();
        check_value("first_arvalid", {31'b0, M_AXI_ARVALID}, 32'd1);
        check_value("first_araddr", M_AXI_ARADDR, 32'h0);
        tick();
        check_value("lat_empty", {31'b0, instr_valid}, 32'd0);
        tick();
        check_value("lat_valid", {31'b0, instr_valid}, 32'd1);
        check_value("lat_pc", instr_pc, 32'h0);
        check_value("lat_data", instr, 32'hFFFF_FFFF);
        repeat (20) tick();
        for (int i = 0; i < 8; i++) begin
            e = 32'(i * 4);
            check_value("stream_araddr", ar_at(i), e);
            check_value("stream_pc", pc_at(i), e);
            check_value("stream_data", data_at(i), ~e);
            check_value("stream_fault", fault_at(i), 32'd0);
        end
        check_value("throughput", (out_cyc.size() >= 8) ? 32'(out_cyc[7] - out_cyc[0]) : 32'hFFFF, 32'd7);

        // Consumer stalled: credits limit issue to the buffer depth
        do_reset(1'b1, 0, 1'b0, 1'b0);
        repeat (30) tick();
        check_value("full_ar_count", 32'(ar_log.size()), 32'd4);
        check_value("full_arvalid", {31'b0, M_AXI_ARVALID}, 32'd0);
        check_value("full_ivalid", {31'b0, instr_valid}, 32'd1);
        check_value("full_head_pc", instr_pc, 32'h0);
        check_value("full_none_popped", 32'(out_pc.size()), 32'd0);
        instr_ready = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 5; i++) begin
            check_value("drain_pc", pc_at(i), 32'(i * 4));
        end

        // Redirect with two delayed reads in flight
        do_reset(1'b1, 5, 1'b1, 1'b0);
        wait_ar(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        repeat (40) tick();
        check_value("redir_pc0", pc_at(0), 32'h0);
        check_value("redir_pc1", pc_at(1), 32'h4);
        check_value("redir_pc2", pc_at(2), 32'h100);
        check_value("redir_data2", data_at(2), 32'hFFFF_FEFF);
        check_value("redir_pc3", pc_at(3), 32'h104);
        check_value("redir_ar4", ar_at(4), 32'h100);

        // Redirect while an AR is held by the slave
        do_reset(1'b0, 0, 1'b1, 1'b0);
        tick();
        check_value("hold_arvalid", {31'b0, M_AXI_ARVALID}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0101;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_value("hold_arvalid_kept", {31'b0, M_AXI_ARVALID}, 32'd1);
            check_value("hold_araddr_kept", M_AXI_ARADDR, 32'h0);
            if (i < 2) tick();
        end
        ar_ready_en = 1'b1;
        repeat (20) tick();
        check_value("hold_ar0", ar_at(0), 32'h0);
        check_value("hold_ar1", ar_at(1), 32'h100);
        check_value("hold_pc0", pc_at(0), 32'h100);
        check_value("hold_pc1", pc_at(1), 32'h104);

        // Error response on one fetch
        do_reset(1'b1, 0, 1'b1, 1'b1);
        repeat (20) tick();
        check_value("fault_pc0", pc_at(0), 32'h0);
        check_value("fault_f0", fault_at(0), 32'd0);
        check_value("fault_pc1", pc_at(1), 32'h4);
        check_value("fault_f1", fault_at(1), 32'd1);
        check_value("fault_data1", data_at(1), 32'hFFFF_FFFB);
        check_value("fault_pc2", pc_at(2), 32'h8);
        check_value("fault_f2", fault_at(2), 32'd0);
        check_value("fault_ar3", ar_at(3), 32'hC);

        // Fetch stall with two reads outstanding
        do_reset(1'b1, 5, 1'b1, 1'b0);
        wait_ar(2);
        fetch_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("stall_arvalid", {31'b0, M_AXI_ARVALID}, 32'd0);
        end
        check_value("stall_ar_count", 32'(ar_log.size()), 32'd2);
        check_value("stall_delivered", 32'(out_pc.size()), 32'd2);
        check_value("stall_pc1", pc_at(1), 32'h4);
        fetch_stall = 1'b0;
        tick();
        check_value("resume_arvalid", {31'b0, M_AXI_ARVALID}, 32'd1);
        check_value("resume_araddr", M_AXI_ARADDR, 32'h8);

        check_value("rready_low", 32'(rready_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
